// File: rtl/m_wb_uart_tx_defs.sv
// rtl/m_wb_uart_tx_defs.sv - register map, bit positions and TX state encodings
// M_WB_UART_TX_PARITY_EN adds the PARITY state.
package m_wb_uart_tx_defs;

    localparam logic [1:0] ADR_TXDATA  = 2'd0;
    localparam logic [1:0] ADR_STATUS  = 2'd1;
    localparam logic [1:0] ADR_CTRL    = 2'd2;
    localparam logic [1:0] ADR_DIVISOR = 2'd3;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVERRUN = 3;
    localparam int ST_COUNT   = 8;

    localparam int CTRL_IRQEN  = 0;
    localparam int CTRL_PARITY = 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
`ifdef M_WB_UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP  = 3'd4
    } tx_state_e;

endpackage

// File: rtl/m_wb_uart_tx_fifo.sv
// rtl/m_wb_uart_tx_fifo.sv - synchronous FIFO, 2^AW entries, show-ahead read port
module m_wb_uart_tx_fifo #(
    parameter int AW = 2,
    parameter int W  = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);
    localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

    logic [W-1:0]  mem_q [0:(1<<AW)-1];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    // Fullness is judged on the registered count, so a full FIFO drops a push even when popping.
    assign full_o  = (count_q == DEPTH);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok)
            count_d = count_q + (AW+1)'(1);
        else if (pop_ok && !push_ok)
            count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/m_wb_uart_tx.sv
// rtl/m_wb_uart_tx.sv - Wishbone classic UART transmitter with TX FIFO and level irq
// M_WB_UART_TX_PARITY_EN enables the even-parity bit (CTRL bit1).
module m_wb_uart_tx
    import m_wb_uart_tx_defs::*;
#(
    parameter int unsigned CLKDIV = 286,
    parameter int          FIFOAW = 2
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [1:0]  ADR_I,
    input  logic [31:0] DAT_I,
    input  logic [3:0]  SEL_I,
    output logic [31:0] DAT_O,
    output logic        ACK_O,
    output logic        TXD,
    output logic        irq
);
    logic        ack_q, irq_q, irqen_q, ovr_q;
    logic [31:0] dat_q, rd_data;
    logic [15:0] div_q, reload;
    logic        req, wr_sel0, wr_txdata;
    logic        fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_dout;
    logic [FIFOAW:0] fifo_count;
    logic        unused_bits;

    tx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shr_q, shr_d;
    logic        txd_q, txd_d;
    logic        tick;
`ifdef M_WB_UART_TX_PARITY_EN
    logic        par_en_q, par_q, par_d;
`endif

    assign req       = CYC_I & STB_I & ~ack_q;
    assign wr_sel0   = req & WE_I & SEL_I[0];
    assign wr_txdata = wr_sel0 & (ADR_I == ADR_TXDATA);
    assign reload    = (div_q < 16'd2) ? 16'd1 : div_q - 16'd1;
    assign tick      = (cnt_q == 16'd0);
    assign unused_bits = ^{DAT_I[31:16], SEL_I[3:2]};

    assign ACK_O = ack_q;
    assign DAT_O = dat_q;
    assign TXD   = txd_q;
    assign irq   = irq_q;

    m_wb_uart_tx_fifo #(.AW(FIFOAW), .W(8)) u_fifo (
        .clk_i   (CLK_I),
        .rst_i   (RST_I),
        .push_i  (wr_txdata),
        .pop_i   (fifo_pop),
        .din_i   (DAT_I[7:0]),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        rd_data = 32'd0;
        case (ADR_I)
            ADR_STATUS: begin
                rd_data[ST_FULL]    = fifo_full;
                rd_data[ST_EMPTY]   = fifo_empty;
                rd_data[ST_BUSY]    = (state_q != S_IDLE);
                rd_data[ST_OVERRUN] = ovr_q;
                rd_data[ST_COUNT +: FIFOAW+1] = fifo_count;
            end
            ADR_CTRL: begin
                rd_data[CTRL_IRQEN] = irqen_q;
`ifdef M_WB_UART_TX_PARITY_EN
                rd_data[CTRL_PARITY] = par_en_q;
`endif
            end
            ADR_DIVISOR: rd_data[15:0] = div_q;
            default: ;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            ack_q   <= 1'b0;
            dat_q   <= 32'd0;
            irq_q   <= 1'b0;
            irqen_q <= 1'b0;
            ovr_q   <= 1'b0;
            div_q   <= 16'(CLKDIV);
`ifdef M_WB_UART_TX_PARITY_EN
            par_en_q <= 1'b0;
`endif
        end else begin
            ack_q <= req;
            dat_q <= (req && !WE_I) ? rd_data : 32'd0;
            irq_q <= irqen_q & fifo_empty & (state_q == S_IDLE);
            if (wr_txdata && fifo_full)
                ovr_q <= 1'b1;
            else if (wr_sel0 && ADR_I == ADR_STATUS && DAT_I[ST_OVERRUN])
                ovr_q <= 1'b0;
            if (wr_sel0 && ADR_I == ADR_CTRL) begin
                irqen_q <= DAT_I[CTRL_IRQEN];
`ifdef M_WB_UART_TX_PARITY_EN
                par_en_q <= DAT_I[CTRL_PARITY];
`endif
            end
            if (req && WE_I && ADR_I == ADR_DIVISOR) begin
                if (SEL_I[0]) div_q[7:0]  <= DAT_I[7:0];
                if (SEL_I[1]) div_q[15:8] <= DAT_I[15:8];
            end
        end
    end

    // txd_d is the line level for the state being entered, so TXD comes straight from a flop.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shr_d    = shr_q;
        txd_d    = txd_q;
        fifo_pop = 1'b0;
`ifdef M_WB_UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        if (state_q != S_IDLE && !tick)
            cnt_d = cnt_q - 16'd1;
        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shr_d    = fifo_dout;
                    cnt_d    = reload;
                    state_d  = S_START;
                    txd_d    = 1'b0;
`ifdef M_WB_UART_TX_PARITY_EN
                    par_d    = ^fifo_dout;
`endif
                end
            end
            S_START: if (tick) begin
                cnt_d   = reload;
                bit_d   = 3'd0;
                state_d = S_DATA;
                txd_d   = shr_q[0];
            end
            S_DATA: if (tick) begin
                cnt_d = reload;
                if (bit_q == 3'd7) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
`ifdef M_WB_UART_TX_PARITY_EN
                    if (par_en_q) begin
                        state_d = S_PARITY;
                        txd_d   = par_q;
                    end
`endif
                end else begin
                    bit_d = bit_q + 3'd1;
                    shr_d = shr_q >> 1;
                    txd_d = shr_q[1];
                end
            end
`ifdef M_WB_UART_TX_PARITY_EN
            S_PARITY: if (tick) begin
                cnt_d   = reload;
                state_d = S_STOP;
                txd_d   = 1'b1;
            end
`endif
            S_STOP: if (tick) begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            shr_q   <= 8'd0;
            txd_q   <= 1'b1;
`ifdef M_WB_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shr_q   <= shr_d;
            txd_q   <= txd_d;
`ifdef M_WB_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_m_wb_uart_tx.sv
// tb/tb_m_wb_uart_tx.sv - self-checking bench for m_wb_uart_tx (register table plus frame sequences)
module tb_m_wb_uart_tx;

    logic        CLK_I, RST_I, CYC_I, STB_I, WE_I;
    logic [1:0]  ADR_I;
    logic [31:0] DAT_I, DAT_O;
    logic [3:0]  SEL_I;
    logic        ACK_O, TXD, irq;

    int checks = 0;
    int errors = 0;

`ifdef M_WB_UART_TX_PARITY_EN
    localparam logic [31:0] CTRL_RB = 32'h3;
`else
    localparam logic [31:0] CTRL_RB = 32'h1;
`endif

    typedef struct {
        logic        we;
        logic [1:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [0:21];
    logic rec [$];
    logic rec_en = 1'b0;

    m_wb_uart_tx dut (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .CYC_I (CYC_I),
        .STB_I (STB_I),
        .WE_I  (WE_I),
        .ADR_I (ADR_I),
        .DAT_I (DAT_I),
        .SEL_I (SEL_I),
        .DAT_O (DAT_O),
        .ACK_O (ACK_O),
        .TXD   (TXD),
        .irq   (irq)
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    always @(negedge CLK_I) if (rec_en) rec.push_back(TXD);

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic wb(input logic we, input logic [1:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = dat; SEL_I = sel;
        tick();
        chk("ack", {31'd0, ACK_O}, 32'd1);
        rd = DAT_O;
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; DAT_I = 32'd0; SEL_I = 4'd0;
        tick();
    endtask

    task automatic wr(input logic [1:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] r;
        wb(1'b1, adr, dat, sel, r);
    endtask

    task automatic rdchk(input string nm, input logic [1:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        wb(1'b0, adr, 32'd0, 4'hF, r);
        chk(nm, r, exp);
    endtask

    task automatic wait_idle(input string nm);
        logic [31:0] s;
        s = 32'hFFFF_FFFF;
        for (int i = 0; i < 300; i++) begin
            wb(1'b0, 2'd1, 32'd0, 4'hF, s);
            if (s == 32'h2) break;
        end
        chk(nm, s, 32'h2);
    endtask

    // Expects to be entered no later than the start bit; checks every sample of every bit.
    task automatic check_frame(input string nm, input logic [7:0] b, input int per, input bit par);
        logic [10:0] exp;
        logic [7:0]  samp, mask;
        int nb, n;
        nb = par ? 11 : 10;
        exp = 11'h7FF;
        exp[0] = 1'b0;
        exp[8:1] = b;
        if (par) exp[9] = ^b;
        mask = 8'((1 << per) - 1);
        n = 0;
        while (TXD && n < 400) begin tick(); n++; end
        if (TXD) begin
            chk({nm, "_start_timeout"}, {31'd0, TXD}, 32'd0);
            return;
        end
        for (int k = 0; k < nb; k++) begin
            samp = 8'd0;
            for (int c = 0; c < per; c++) begin
                samp[c] = TXD;
                tick();
            end
            chk($sformatf("%s_bit%0d", nm, k), {24'd0, samp}, exp[k] ? {24'd0, mask} : 32'd0);
        end
        rdchk({nm, "_len"}, 2'd1, 32'h2);
    endtask

    initial begin
        logic [3:0]  ap;
        logic [7:0]  got [$];
        logic [31:0] r;
        int hi, i;

        RST_I = 1'b1; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        ADR_I = 2'd0; DAT_I = 32'd0; SEL_I = 4'd0;

        tbl[0]  = '{1'b0, 2'd1, 32'h0,        4'hF, 32'h2};
        tbl[1]  = '{1'b0, 2'd2, 32'h0,        4'hF, 32'h0};
        tbl[2]  = '{1'b0, 2'd3, 32'h0,        4'hF, 32'h11E};
        tbl[3]  = '{1'b0, 2'd0, 32'h0,        4'hF, 32'h0};
        tbl[4]  = '{1'b1, 2'd3, 32'h4,        4'h3, 32'h0};
        tbl[5]  = '{1'b0, 2'd3, 32'h0,        4'hF, 32'h4};
        tbl[6]  = '{1'b1, 2'd3, 32'hFFFF_FF07, 4'h1, 32'h0};
        tbl[7]  = '{1'b0, 2'd3, 32'h0,        4'hF, 32'h7};
        tbl[8]  = '{1'b1, 2'd3, 32'h0000_0300, 4'h2, 32'h0};
        tbl[9]  = '{1'b0, 2'd3, 32'h0,        4'hF, 32'h307};
        tbl[10] = '{1'b1, 2'd3, 32'hABCD_0004, 4'h3, 32'h0};
        tbl[11] = '{1'b0, 2'd3, 32'h0,        4'hF, 32'h4};
        tbl[12] = '{1'b1, 2'd2, 32'hFFFF_FFFF, 4'h1, 32'h0};
        tbl[13] = '{1'b0, 2'd2, 32'h0,        4'hF, CTRL_RB};
        tbl[14] = '{1'b1, 2'd2, 32'h0,        4'h0, 32'h0};
        tbl[15] = '{1'b0, 2'd2, 32'h0,        4'hF, CTRL_RB};
        tbl[16] = '{1'b1, 2'd2, 32'h0,        4'h1, 32'h0};
        tbl[17] = '{1'b0, 2'd2, 32'h0,        4'hF, 32'h0};
        tbl[18] = '{1'b1, 2'd0, 32'h99,       4'h2, 32'h0};
        tbl[19] = '{1'b0, 2'd1, 32'h0,        4'hF, 32'h2};
        tbl[20] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 4'h1, 32'h0};
        tbl[21] = '{1'b0, 2'd1, 32'h0,        4'hF, 32'h2};

        tick(); tick();
        chk("rst_ack", {31'd0, ACK_O}, 32'd0);
        chk("rst_dat", DAT_O, 32'd0);
        chk("rst_txd", {31'd0, TXD}, 32'd1);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        RST_I = 1'b0;
        tick();

        for (int v = 0; v < 22; v++) begin
            wb(tbl[v].we, tbl[v].adr, tbl[v].dat, tbl[v].sel, r);
            chk($sformatf("vec%0d", v), r, tbl[v].exp);
        end

        // Request withdrawn before the clock edge must leave no trace.
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = 2'd3; DAT_I = 32'h55; SEL_I = 4'h3;
        #2;
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; DAT_I = 32'd0; SEL_I = 4'd0;
        tick();
        chk("abort_ack", {31'd0, ACK_O}, 32'd0);
        tick();
        rdchk("abort_div", 2'd3, 32'h4);

        wr(2'd0, 32'hA5, 4'h1);
        check_frame("frame_a5", 8'hA5, 4, 1'b0);

        wr(2'd0, 32'h11, 4'h1);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = 2'd0; DAT_I = 32'h22; SEL_I = 4'h1;
        ap[3] = ACK_O; tick();
        ap[2] = ACK_O; tick();
        ap[1] = ACK_O; tick();
        ap[0] = ACK_O; tick();
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; DAT_I = 32'd0; SEL_I = 4'd0;
        chk("hs_ack_pattern", {28'd0, ap}, 32'h5);
        rdchk("hs_status", 2'd1, 32'h204);
        wait_idle("hs_drain");

        rec.delete();
        rec_en = 1'b1;
        for (int k = 0; k < 6; k++) wr(2'd0, 32'h31 + k, 4'h1);
        rdchk("ovr_status", 2'd1, 32'h40D);
        wr(2'd1, 32'h8, 4'h1);
        rdchk("ovr_cleared", 2'd1, 32'h405);
        wait_idle("ovr_drain");
        rec_en = 1'b0;
        i = 1;
        while (i < rec.size()) begin
            if (rec[i-1] && !rec[i] && i + 38 < rec.size()) begin
                logic [7:0] b;
                for (int j = 0; j < 8; j++) b[j] = rec[i + 4*(j+1) + 2];
                got.push_back(b);
                i += 40;
            end else begin
                i++;
            end
        end
        chk("ovr_frames", got.size(), 32'd5);
        for (int k = 0; k < 5; k++)
            chk($sformatf("ovr_byte%0d", k), (k < got.size()) ? {24'd0, got[k]} : 32'hDEAD, 32'h31 + k);

        wr(2'd2, 32'h1, 4'h1);
        tick();
        chk("irq_idle", {31'd0, irq}, 32'd1);
        wr(2'd0, 32'h5A, 4'h1);
        chk("irq_frame_start_txd", {31'd0, TXD}, 32'd0);
        hi = 0;
        for (int c = 0; c <= 40; c++) begin
            if (irq) hi++;
            tick();
        end
        chk("irq_during_frame", hi, 32'd0);
        chk("irq_after_stop", {31'd0, irq}, 32'd1);
        wr(2'd2, 32'h0, 4'h1);
        chk("irq_disabled", {31'd0, irq}, 32'd0);

        wr(2'd3, 32'h1, 4'h3);
        wr(2'd0, 32'h07, 4'h1);
        check_frame("frame_div1", 8'h07, 2, 1'b0);

`ifdef M_WB_UART_TX_PARITY_EN
        wr(2'd3, 32'h2, 4'h3);
        wr(2'd2, 32'h3, 4'h1);
        wr(2'd0, 32'h07, 4'h1);
        check_frame("frame_par", 8'h07, 2, 1'b1);
        wr(2'd2, 32'h0, 4'h1);
`endif

        wr(2'd3, 32'h4, 4'h3);
        wr(2'd0, 32'h55, 4'h1);
        wr(2'd0, 32'h66, 4'h1);
        chk("pre_reset_txd", {31'd0, TXD}, 32'd0);
        RST_I = 1'b1;
        #1;
        chk("async_reset_txd", {31'd0, TXD}, 32'd1);
        chk("async_reset_ack", {31'd0, ACK_O}, 32'd0);
        tick(); tick();
        RST_I = 1'b0;
        tick();
        rdchk("post_reset_status", 2'd1, 32'h2);
        rdchk("post_reset_div", 2'd3, 32'h11E);
        rdchk("post_reset_ctrl", 2'd2, 32'h0);
        tick(); tick();
        chk("post_reset_txd", {31'd0, TXD}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
